// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-word circular buffer feeding a registered
// valid/ready output that assembles short (1-word) and long (2-word) instructions.
// Optional legacy bubble mode is enabled by defining IF_ID_QUEUE_BUBBLE_EN.
module if_id_queue #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       LONG_BIT = 15,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0F00,
  parameter int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] fetch_data_in,
  input  logic              fetch_valid_in,
  output logic              fetch_ready_out,
  input  logic              flush_in,
  output logic [DATA_W-1:0] instruc_out,
  output logic [DATA_W-1:0] imediat_out,
  output logic              long_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [CNT_W-1:0]  count_out
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef IF_ID_QUEUE_BUBBLE_EN
  localparam bit BubbleEn = 1'b1;
`else
  localparam bit BubbleEn = 1'b0;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] instr_q, instr_d, imm_q, imm_d;
  logic              long_q, long_d, valid_q, valid_d;

  logic [PtrW-1:0]   rd_ptr_1, rd_ptr_2;
  logic [DATA_W-1:0] head, head_next;
  logic              head_long, complete, load, push;
  logic [1:0]        pop_n;

  assign rd_ptr_1  = ptr_inc(rd_ptr_q);
  assign rd_ptr_2  = ptr_inc(rd_ptr_1);
  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_ptr_1];
  assign head_long = head[LONG_BIT];

  // Ready looks only at the registered count so it never depends on a same-cycle pop.
  assign fetch_ready_out = (count_q < CNT_W'(DEPTH)) && !flush_in;
  assign push            = fetch_valid_in && fetch_ready_out;

  assign complete = head_long ? (count_q >= CNT_W'(2)) : (count_q >= CNT_W'(1));
  assign load     = (!valid_q || ready_in) && complete && !flush_in;
  assign pop_n    = load ? (head_long ? 2'd2 : 2'd1) : 2'd0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    imm_d    = imm_q;
    long_d   = long_q;
    valid_d  = valid_q;

    if (flush_in) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      instr_d  = NOP_WORD;
      imm_d    = '0;
      long_d   = 1'b0;
      valid_d  = BubbleEn;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop_n);

      if (load) begin
        instr_d  = head;
        imm_d    = head_long ? head_next : '0;
        long_d   = head_long;
        valid_d  = 1'b1;
        rd_ptr_d = head_long ? rd_ptr_2 : rd_ptr_1;
      end else if ((valid_q && ready_in) || (BubbleEn && !valid_q)) begin
        // Output consumed (or idle in bubble mode) with nothing complete behind it.
        instr_d = NOP_WORD;
        imm_d   = '0;
        long_d  = 1'b0;
        valid_d = BubbleEn;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= NOP_WORD;
      imm_q    <= '0;
      long_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      imm_q    <= imm_d;
      long_q   <= long_d;
      valid_q  <= valid_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= fetch_data_in;
    end
  end

  assign instruc_out = instr_q;
  assign imediat_out = imm_q;
  assign long_out    = long_q;
  assign valid_out   = valid_q;
  assign count_out   = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (default parameters).
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] fetch_data_in = '0;
  logic        fetch_valid_in = 1'b0;
  logic        fetch_ready_out;
  logic        flush_in = 1'b0;
  logic [15:0] instruc_out;
  logic [15:0] imediat_out;
  logic        long_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [2:0]  count_out;

  int n_pass  = 0;
  int n_total = 0;

`ifdef IF_ID_QUEUE_BUBBLE_EN
  localparam logic BubbleV = 1'b1;
`else
  localparam logic BubbleV = 1'b0;
`endif

  if_id_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fetch_data_in  (fetch_data_in),
    .fetch_valid_in (fetch_valid_in),
    .fetch_ready_out(fetch_ready_out),
    .flush_in       (flush_in),
    .instruc_out    (instruc_out),
    .imediat_out    (imediat_out),
    .long_out       (long_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .count_out      (count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fetch_data_in  = w;
    fetch_valid_in = 1'b1;
    tick();
    fetch_valid_in = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] ins, input logic [15:0] imm,
                           input logic lng, input logic vld);
    check({tag, "_instr"}, 32'(instruc_out), 32'(ins));
    check({tag, "_imm"},   32'(imediat_out), 32'(imm));
    check({tag, "_long"},  32'(long_out),    32'(lng));
    check({tag, "_valid"}, 32'(valid_out),   32'(vld));
  endtask

  logic [15:0] t5_words [10];
  logic [15:0] t5_ins   [8];
  logic [15:0] t5_imm   [8];
  logic        t5_long  [8];
  int          t5_idx;

  task automatic t5_sample();
    if (valid_out && instruc_out != 16'h0F00) begin
      if (t5_idx < 8) begin
        check("t5_instr", 32'(instruc_out), 32'(t5_ins[t5_idx]));
        check("t5_imm",   32'(imediat_out), 32'(t5_imm[t5_idx]));
        check("t5_long",  32'(long_out),    32'(t5_long[t5_idx]));
      end
      t5_idx++;
    end
  endtask

  initial begin
    // Reset state, held across two edges
    tick();
    tick();
    check_out("rst", 16'h0F00, 16'h0000, 1'b0, 1'b0);
    check("rst_count", 32'(count_out), 32'd0);
    reset_n = 1'b1;
    #1;
    check("rst_ready", 32'(fetch_ready_out), 32'd1);
    ready_in = 1'b1;
    if (BubbleV) tick();  // let the bubble settle before the functional tests

    // 1: short instruction
    push(16'h1234);
    check("t1_count_wr", 32'(count_out), 32'd1);
    tick();
    check_out("t1", 16'h1234, 16'h0000, 1'b0, 1'b1);
    check("t1_count", 32'(count_out), 32'd0);
    tick();
    check_out("t1_drain", 16'h0F00, 16'h0000, 1'b0, BubbleV);

    // 2: long instruction split across cycles
    push(16'h8A21);
    tick();
    tick();
    check("t2_wait_count", 32'(count_out), 32'd1);
    check("t2_wait_instr", 32'(instruc_out), 32'h0F00);
    push(16'h00FF);
    tick();
    check_out("t2", 16'h8A21, 16'h00FF, 1'b1, 1'b1);
    check("t2_count", 32'(count_out), 32'd0);
    tick();

    // 3: stall until full, then release
    ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) push(16'(i));
    check_out("t3_hold", 16'h0001, 16'h0000, 1'b0, 1'b1);
    check("t3_full_count", 32'(count_out), 32'd4);
    check("t3_full_ready", 32'(fetch_ready_out), 32'd0);
    push(16'h0006);
    check("t3_rej_count", 32'(count_out), 32'd4);
    check("t3_rej_instr", 32'(instruc_out), 32'h0001);
    ready_in = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick();
      check("t3_drain_instr", 32'(instruc_out), 32'(i));
      check("t3_drain_valid", 32'(valid_out), 32'd1);
    end
    check("t3_drain_count", 32'(count_out), 32'd0);
    tick();
    check_out("t3_empty", 16'h0F00, 16'h0000, 1'b0, BubbleV);
    check("t3_empty_count", 32'(count_out), 32'd0);

    // 4: flush with half a long instruction queued
    push(16'h8000);
    check("t4_half_count", 32'(count_out), 32'd1);
    flush_in = 1'b1;
    fetch_data_in = 16'h7777;
    fetch_valid_in = 1'b1;
    #1;
    check("t4_flush_ready", 32'(fetch_ready_out), 32'd0);
    tick();
    flush_in = 1'b0;
    fetch_valid_in = 1'b0;
    check("t4_flush_count", 32'(count_out), 32'd0);
    check_out("t4_flush", 16'h0F00, 16'h0000, 1'b0, BubbleV);
    push(16'h0001);
    check("t4_after_count", 32'(count_out), 32'd1);
    tick();
    check_out("t4_after", 16'h0001, 16'h0000, 1'b0, 1'b1);
    tick();

    // 5: continuous push with wrap-around and simultaneous push/pop
    t5_words = '{16'h0001, 16'h8002, 16'h0003, 16'h0004, 16'h8005,
                 16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A};
    t5_ins  = '{16'h0001, 16'h8002, 16'h0004, 16'h8005,
                16'h0007, 16'h0008, 16'h0009, 16'h000A};
    t5_imm  = '{16'h0000, 16'h0003, 16'h0000, 16'h0006,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    t5_long = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t5_idx  = 0;
    for (int i = 0; i < 10; i++) begin
      push(t5_words[i]);
      t5_sample();
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      t5_sample();
    end
    check("t5_n_out", 32'(t5_idx), 32'd8);
    check("t5_count", 32'(count_out), 32'd0);

    // 6: asynchronous reset while stalled with a full queue
    ready_in = 1'b0;
    for (int i = 1; i <= 5; i++) push(16'h0010 + 16'(i));
    check("t6_full_count", 32'(count_out), 32'd4);
    check("t6_full_instr", 32'(instruc_out), 32'h0011);
    #2 reset_n = 1'b0;
    #1;
    check_out("t6_rst", 16'h0F00, 16'h0000, 1'b0, 1'b0);
    check("t6_rst_count", 32'(count_out), 32'd0);
    #2 reset_n = 1'b1;
    tick();
    check_out("t6_post", 16'h0F00, 16'h0000, 1'b0, BubbleV);
    check("t6_post_count", 32'(count_out), 32'd0);
    check("t6_post_ready", 32'(fetch_ready_out), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised successor to the IF/ID interface.
- Buffers fetched instruction words in a DEPTH-entry circular queue.
- Assembles short (1-word) and long (2-word, opcode + immediate) instructions and presents them to ID through a registered output with a valid/ready handshake.
- Adds the stall, flush and back-pressure behaviour the pipeline needs once branches and hazards are handled.

Parameters:
- DATA_W, 16, instruction word width.
- DEPTH, 4, queue depth in words; legal values are 2 or more, any integer.
- LONG_BIT, 15, bit index of the incoming word that marks a long (2-word) instruction.
- NOP_WORD, 16'h0F00, value driven on instruc_out when no instruction is held.
- CNT_W, $clog2(DEPTH+1), width of count_out.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- fetch_data_in  in  DATA_W  word fetched from instruction memory.
- fetch_valid_in  in  1  fetch_data_in is valid this cycle.
- fetch_ready_out  out  1  queue accepts a word this cycle.
- flush_in  in  1  synchronous flush (taken branch/jump).
- instruc_out  out  DATA_W  first word of the presented instruction.
- imediat_out  out  DATA_W  second word for long instructions, 0 for short ones.
- long_out  out  1  presented instruction is long.
- valid_out  out  1  instruc_out/imediat_out hold a real instruction.
- ready_in  in  1  ID consumes the presented instruction this cycle.
- count_out  out  CNT_W  words currently in the queue, excluding the output register.

Behaviour:
- Reset, while reset_n = 0, asynchronous:
  - read pointer, write pointer and count = 0;
  - valid_out = 0, long_out = 0;
  - instruc_out = NOP_WORD, imediat_out = 0;
  - fetch_ready_out = 1 once reset is released.
  - Reset asserted mid-operation discards all content, including half of a long instruction.
- fetch_ready_out = (count < DEPTH) and not flush_in. It is combinational from registered count only and never depends on pop in the same cycle.
- Push: fetch_valid_in & fetch_ready_out writes at the write pointer, which then increments modulo DEPTH.
- Head decode:
  - head word[LONG_BIT] = 0 and count ≥ 1: a short instruction is complete.
  - head word[LONG_BIT] = 1 and count ≥ 2: a long instruction is complete.
  - head long with count = 1: incomplete; wait, no pop.
- Load condition: (!valid_out | ready_in) & complete. On load:
  - short: instruc_out = head, imediat_out = 0, long_out = 0, valid_out = 1; pop 1.
  - long: instruc_out = head, imediat_out = head+1 (modulo DEPTH), long_out = 1, valid_out = 1; pop 2.
  - Read pointer advances modulo DEPTH.
- Consumed without reload: if ready_in & valid_out and the load condition is false, then on the next edge valid_out = 0, instruc_out = NOP_WORD, imediat_out = 0, long_out = 0.
- Stall: valid_out & !ready_in holds all outputs stable. The queue keeps filling until count = DEPTH.
- Simultaneous push and pop in one cycle is legal: count_next = count + push − pop (pop ∈ {0,1,2}). A pushed word is never part of the same-cycle load; there is no bypass.
- Latency: a word written at edge N reaches the outputs at edge N+1 at the earliest, provided the output register is free.
- Flush, flush_in = 1 at an edge; highest priority after reset:
  - pointers and count = 0;
  - valid_out = 0, outputs at NOP/0 values;
  - any push in that cycle is ignored;
  - ready_in is ignored.
- Order is strictly preserved; no word is duplicated or dropped except by flush or reset.

Optional Feature:
- Macro IF_ID_QUEUE_BUBBLE_EN.
- Defined (legacy mode, for pipeline stages without stall logic):
  - valid_out is forced to 1 after reset and after flush;
  - whenever no complete instruction is loaded, the output register presents instruc_out = NOP_WORD, imediat_out = 0, long_out = 0 as an ordinary consumable bubble;
  - ready_in still controls holding.
- Undefined: behaviour as above; valid_out = 0 when empty.

Test Plan:
1. Short instruction: reset, ready_in = 1, push 16'h1234 at edge N -> at edge N+1 instruc_out = 16'h1234, imediat_out = 0, long_out = 0, valid_out = 1, count_out = 0.
2. Long instruction split across cycles: push 16'h8A21, idle 2 cycles, push 16'h00FF -> valid_out stays 0 with count_out = 1 while waiting; one edge after the second push, instruc_out = 16'h8A21, imediat_out = 16'h00FF, long_out = 1.
3. Stall/full, DEPTH = 4, ready_in = 0: push shorts 1,2,3,4,5 back-to-back:
   - instruc_out holds 1;
   - count_out reaches 4 and fetch_ready_out = 0;
   - an extra push of 6 is not accepted;
   - releasing ready_in yields 2,3,4,5 on consecutive cycles, then valid_out = 0.
4. Flush mid-long: push 16'h8000 only, assert flush_in together with a push of 16'h7777 -> count_out = 0, valid_out = 0, 16'h7777 is not stored; a subsequent push of 16'h0001 emits a short 16'h0001.
5. Wrap-around and simultaneous push/pop, ready_in = 1: continuously push 0x0001, 0x8002, 0x0003, 0x0004, 0x8005, 0x0006, 0x0007, 0x0008, 0x0009, 0x000A -> outputs in order:
   - short 0x0001;
   - long 0x8002 with imm 0x0003;
   - short 0x0004;
   - long 0x8005 with imm 0x0006;
   - shorts 0x0007, 0x0008, 0x0009, 0x000A;
   - no loss with pointers wrapping twice.
6. Asynchronous reset mid-stall with the queue full: drop reset_n between edges -> outputs go to NOP/0 and valid_out = 0 immediately; count_out = 0. With IF_ID_QUEUE_BUBBLE_EN defined, valid_out = 1 with NOP_WORD after the first edge after reset release.
